mem_bist_ctrl: RTL
==================

// Module: mem_bist_ctrl
// PURPOSE
//  Synthesizable memory built-in self-test sequencer. Drives the same memory port as the
//  memory testbench (addr, data_in, read, write in; data_out back) and runs two tests:
//  Clear (write 0, read/check) and Data=Address (write addr, read/check).
//  Reports pass/fail, a saturating error count and the first failing address to SoC status logic.
// PARAMETERS
//  ADDR_WIDTH     5  memory address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH     8  memory data width; expected data = zero-extended/truncated address
//  ERR_CNT_WIDTH  8  width of error counter (saturates at all-ones)
// PORTS
//  clk           in   1           rising-edge clock, shared with memory
//  rst_          in   1           asynchronous active-low reset
//  start         in   1           1-cycle request; sampled only in IDLE or DONE
//  busy          out  1           high while a test sequence is in progress
//  done          out  1           high from sequence end until next start or reset
//  pass          out  1           valid when done: 1 if err_count==0
//  err_count     out  ERR_CNT_WIDTH  total mismatches, both tests, saturating
//  fail_addr     out  ADDR_WIDTH  address of first mismatch (0 if none)
//  mem_addr      out  ADDR_WIDTH  memory address
//  mem_data_in   out  DATA_WIDTH  memory write data
//  mem_write     out  1           memory write strobe (written on clk edge)
//  mem_read      out  1           memory read strobe
//  mem_data_out  in   DATA_WIDTH  memory read data, valid 1 cycle after mem_read
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/captures 0. Reset mid-sequence aborts at once;
//   no partial result kept; memory contents are not restored.
//  States: IDLE -> CLR_WR -> CLR_RD -> DA_WR -> DA_RD -> DRAIN -> DONE; DONE -> CLR_WR on start.
//  start seen in IDLE/DONE at cycle 0: err_count, fail_addr, pass, done cleared at cycle 1.
//  Each WR/RD state lasts exactly 2**ADDR_WIDTH cycles, address 0 up to max; address counter
//   wraps to 0 at each phase change. mem_read and mem_write are never both high.
//  CLR_WR: write=1, data_in=0.  DA_WR: write=1, data_in=addr.  RD states: read=1, data_in=0.
//  Compare pipeline: on each read cycle, register {valid, addr, expected}; compare
//   mem_data_out against it on the next cycle using !== (X/Z counts as mismatch).
//   The last CLR_RD compare overlaps the first DA_WR cycle. DRAIN performs only the last
//   DA_RD compare; no memory access.
//  Mismatch: err_count++ (hold at all-ones); if it was 0 before, capture fail_addr.
//  Timing for ADDR_WIDTH=5: busy high cycles 1..129; done=1 and pass valid from cycle 130.
//   Total latency = 4*2**ADDR_WIDTH + 2 cycles from start.
//  start while busy: ignored. Memory strobes are all 0 in IDLE, DRAIN and DONE.
// STRUCTURE
//  mem_bist_pkg: state_t enum; test-pattern function exp_data(addr) used by RTL and bench.
//  Sub-module mem_bist_checker: compare pipeline register, saturating err counter,
//   first-fail capture. Controller holds the FSM, address counter and memory drive.
// TESTING  (32x8 behavioural memory, 1-cycle read latency)
//  1 Reset, start: 130-cycle run -> done=1, pass=1, err_count=0, fail_addr=0, 64 writes, 64 reads.
//  2 Memory bit 3 stuck-at-1 at addr 5 -> err_count=2 (both tests), fail_addr=5, pass=0.
//  3 Data bit 0 stuck-at-0 everywhere -> err_count=16 (DA odd addrs), fail_addr=1.
//  4 All data bits stuck-at-1 -> 64 mismatches; ERR_CNT_WIDTH=5 run saturates at 31.
//  5 start pulsed at cycle 50 -> ignored, run ends at cycle 130; 2nd start in DONE reruns clean.
//  6 rst_ low at cycle 70 (asynchronous, mid-clock) -> all outputs 0 immediately, state IDLE;
//    new start -> full pass.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and test-pattern helper for the memory BIST sequencer.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClrWr,
    StClrRd,
    StDaWr,
    StDaRd,
    StDrain,
    StDone
  } state_t;

  localparam int unsigned PatWidth = 32;

  // Clear test expects zero; Data=Address test expects the address itself.
  function automatic logic [PatWidth-1:0] exp_data(input logic [PatWidth-1:0] addr,
                                                   input logic                 da_test);
    return da_test ? addr : '0;
  endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-compare pipeline with saturating error counter and first-failure address capture.
module mem_bist_checker #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     rd_valid_i,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
  input  logic [DATA_WIDTH-1:0]    rd_exp_i,
  input  logic [DATA_WIDTH-1:0]    mem_data_out_i,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0]    fail_addr_o
);

  logic                     cmp_valid_q;
  logic [ADDR_WIDTH-1:0]    cmp_addr_q;
  logic [DATA_WIDTH-1:0]    cmp_exp_q;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0]    fail_q, fail_d;
  logic                     mismatch;

  // Case inequality so that X/Z read data is flagged as a failure.
  assign mismatch = cmp_valid_q && (mem_data_out_i !== cmp_exp_q);

  always_comb begin
    err_d  = err_q;
    fail_d = fail_q;
    if (clear_i) begin
      err_d  = '0;
      fail_d = '0;
    end else if (mismatch) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) fail_d = cmp_addr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      err_q       <= '0;
      fail_q      <= '0;
    end else begin
      cmp_valid_q <= rd_valid_i;
      cmp_addr_q  <= rd_addr_i;
      cmp_exp_q   <= rd_exp_i;
      err_q       <= err_d;
      fail_q      <= fail_d;
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = fail_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: runs Clear and Data=Address write/read passes over the whole memory.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0]    fail_addr_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_data_in_o,
  output logic                     mem_write_o,
  output logic                     mem_read_o,
  input  logic [DATA_WIDTH-1:0]    mem_data_out_i
);

  localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    accept, last_addr, in_phase, rd_valid;
  logic [DATA_WIDTH-1:0]   rd_exp, clr_pat, da_pat;

  assign accept    = start_i && (state_q == StIdle || state_q == StDone);
  assign last_addr = (addr_q == AddrMax);
  assign in_phase  = state_q inside {StClrWr, StClrRd, StDaWr, StDaRd};
  assign clr_pat   = DATA_WIDTH'(exp_data(PatWidth'(addr_q), 1'b0));
  assign da_pat    = DATA_WIDTH'(exp_data(PatWidth'(addr_q), 1'b1));
  // Counter runs through all addresses in each phase and naturally wraps to 0 at the boundary.
  assign addr_d    = in_phase ? addr_q + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (accept) state_d = StClrWr;
      StClrWr:        if (last_addr) state_d = StClrRd;
      StClrRd:        if (last_addr) state_d = StDaWr;
      StDaWr:         if (last_addr) state_d = StDaRd;
      StDaRd:         if (last_addr) state_d = StDrain;
      StDrain:        state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    mem_addr_o    = '0;
    mem_data_in_o = '0;
    mem_write_o   = 1'b0;
    mem_read_o    = 1'b0;
    rd_valid      = 1'b0;
    rd_exp        = '0;
    unique case (state_q)
      StClrWr: begin
        busy_o        = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = addr_q;
        mem_data_in_o = clr_pat;
      end
      StClrRd: begin
        busy_o     = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = addr_q;
        rd_valid   = 1'b1;
        rd_exp     = clr_pat;
      end
      StDaWr: begin
        busy_o        = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = addr_q;
        mem_data_in_o = da_pat;
      end
      StDaRd: begin
        busy_o     = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = addr_q;
        rd_valid   = 1'b1;
        rd_exp     = da_pat;
      end
      StDrain: busy_o = 1'b1;
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign pass_o = done_o && (err_count_o == '0);

  mem_bist_checker #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_checker (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (accept),
    .rd_valid_i     (rd_valid),
    .rd_addr_i      (addr_q),
    .rd_exp_i       (rd_exp),
    .mem_data_out_i (mem_data_out_i),
    .err_count_o    (err_count_o),
    .fail_addr_o    (fail_addr_o)
  );

endmodule
